// File: rtl/fifo.sv
// Synchronous single-clock FIFO with first-word fall-through head output.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky o_overflow/o_underflow.
//
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   o_full, o_empty  occupancy status decoded from the registered count
//   i_enq_data       word to enqueue
//   i_enq_en         enqueue request; accepted when o_enq_rdy
//   o_enq_rdy        ~o_full
//   o_out_data       head-of-queue word, 0 when empty
//   i_deq_en         dequeue request; accepted when o_deq_rdy
//   o_deq_rdy        ~o_empty
//   o_overflow       (FIFO_ERR_FLAGS_EN) sticky: enqueue requested while full
//   o_underflow      (FIFO_ERR_FLAGS_EN) sticky: dequeue requested while empty
module fifo #(
    parameter int unsigned p_WORD_LEN  = 8,
    parameter int unsigned p_FIFO_SIZE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic                  o_full,
    output logic                  o_empty,
    input  logic [p_WORD_LEN-1:0] i_enq_data,
    input  logic                  i_enq_en,
    output logic                  o_enq_rdy,
    output logic [p_WORD_LEN-1:0] o_out_data,
    input  logic                  i_deq_en,
    output logic                  o_deq_rdy
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  o_overflow,
    output logic                  o_underflow
`endif
);

    localparam int unsigned PTR_W = $clog2(p_FIFO_SIZE);
    localparam int unsigned CNT_W = $clog2(p_FIFO_SIZE) + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(p_FIFO_SIZE - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_FIFO_SIZE);

    logic [p_WORD_LEN-1:0] mem [p_FIFO_SIZE];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  enq_fire;
    logic                  deq_fire;

    // Status and handshake decode, all from registered state only
    assign o_full     = (count == FULL_CNT);
    assign o_empty    = (count == '0);
    assign o_enq_rdy  = ~o_full;
    assign o_deq_rdy  = ~o_empty;
    assign enq_fire   = i_enq_en & o_enq_rdy;
    assign deq_fire   = i_deq_en & o_deq_rdy;
    assign o_out_data = o_empty ? '0 : mem[rd_ptr];

    // Storage is never cleared; stale words are masked by o_empty
    always_ff @(posedge i_clk) begin
        if (!i_reset && enq_fire) begin
            mem[wr_ptr] <= i_enq_data;
        end
    end

    // Pointers wrap by explicit compare so non-power-of-two depths work
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky misuse flags, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_enq_en && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_deq_en && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed scoreboard bench for fifo: a default 8x8 instance and a 5-deep
// 16-bit instance, each compared against a queue model after every edge.
module tb_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: 8 words x 8 bits
    logic       a_reset = 1'b1, a_enq_en = 1'b0, a_deq_en = 1'b0;
    logic [7:0] a_enq_data = '0, a_out_data;
    logic       a_full, a_empty, a_enq_rdy, a_deq_rdy, a_ovf, a_unf;

    // Instance B: 5 words x 16 bits
    logic        b_reset = 1'b1, b_enq_en = 1'b0, b_deq_en = 1'b0;
    logic [15:0] b_enq_data = '0, b_out_data;
    logic        b_full, b_empty, b_enq_rdy, b_deq_rdy, b_ovf, b_unf;

    fifo #(.p_WORD_LEN(8), .p_FIFO_SIZE(8)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .o_full(a_full), .o_empty(a_empty),
        .i_enq_data(a_enq_data), .i_enq_en(a_enq_en), .o_enq_rdy(a_enq_rdy),
        .o_out_data(a_out_data), .i_deq_en(a_deq_en), .o_deq_rdy(a_deq_rdy)
`ifdef FIFO_ERR_FLAGS_EN
        , .o_overflow(a_ovf), .o_underflow(a_unf)
`endif
    );

    fifo #(.p_WORD_LEN(16), .p_FIFO_SIZE(5)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .o_full(b_full), .o_empty(b_empty),
        .i_enq_data(b_enq_data), .i_enq_en(b_enq_en), .o_enq_rdy(b_enq_rdy),
        .o_out_data(b_out_data), .i_deq_en(b_deq_en), .o_deq_rdy(b_deq_rdy)
`ifdef FIFO_ERR_FLAGS_EN
        , .o_overflow(b_ovf), .o_underflow(b_unf)
`endif
    );

`ifndef FIFO_ERR_FLAGS_EN
    assign a_ovf = 1'b0;
    assign a_unf = 1'b0;
    assign b_ovf = 1'b0;
    assign b_unf = 1'b0;
`endif

    // Scoreboards and sticky-flag models
    logic [7:0]  q_a[$];
    logic [15:0] q_b[$];
    logic m_a_ovf = 1'b0, m_a_unf = 1'b0, m_b_ovf = 1'b0, m_b_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a();
        chk("a_empty", 32'(a_empty), 32'(q_a.size() == 0));
        chk("a_full", 32'(a_full), 32'(q_a.size() == 8));
        chk("a_enq_rdy", 32'(a_enq_rdy), 32'(q_a.size() != 8));
        chk("a_deq_rdy", 32'(a_deq_rdy), 32'(q_a.size() != 0));
        chk("a_out_data", 32'(a_out_data), (q_a.size() != 0) ? 32'(q_a[0]) : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("a_overflow", 32'(a_ovf), 32'(m_a_ovf));
        chk("a_underflow", 32'(a_unf), 32'(m_a_unf));
`endif
    endtask

    task automatic check_b();
        chk("b_empty", 32'(b_empty), 32'(q_b.size() == 0));
        chk("b_full", 32'(b_full), 32'(q_b.size() == 5));
        chk("b_enq_rdy", 32'(b_enq_rdy), 32'(q_b.size() != 5));
        chk("b_deq_rdy", 32'(b_deq_rdy), 32'(q_b.size() != 0));
        chk("b_out_data", 32'(b_out_data), (q_b.size() != 0) ? 32'(q_b[0]) : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("b_overflow", 32'(b_ovf), 32'(m_b_ovf));
        chk("b_underflow", 32'(b_unf), 32'(m_b_unf));
`endif
    endtask

    // One cycle on instance A: drive at negedge, model at posedge, check just after
    task automatic step_a(input logic rst, input logic en, input logic [7:0] d, input logic de);
        logic acc_e, acc_d, set_o, set_u;
        a_reset = rst; a_enq_en = en; a_enq_data = d; a_deq_en = de;
        acc_e = en && (q_a.size() < 8);
        acc_d = de && (q_a.size() > 0);
        set_o = en && (q_a.size() == 8);
        set_u = de && (q_a.size() == 0);
        @(posedge clk);
        if (rst) begin
            q_a.delete(); m_a_ovf = 1'b0; m_a_unf = 1'b0;
        end else begin
            if (acc_d) void'(q_a.pop_front());
            if (acc_e) q_a.push_back(d);
            if (set_o) m_a_ovf = 1'b1;
            if (set_u) m_a_unf = 1'b1;
        end
        #1 check_a();
        @(negedge clk);
    endtask

    task automatic step_b(input logic rst, input logic en, input logic [15:0] d, input logic de);
        logic acc_e, acc_d, set_o, set_u;
        b_reset = rst; b_enq_en = en; b_enq_data = d; b_deq_en = de;
        acc_e = en && (q_b.size() < 5);
        acc_d = de && (q_b.size() > 0);
        set_o = en && (q_b.size() == 5);
        set_u = de && (q_b.size() == 0);
        @(posedge clk);
        if (rst) begin
            q_b.delete(); m_b_ovf = 1'b0; m_b_unf = 1'b0;
        end else begin
            if (acc_d) void'(q_b.pop_front());
            if (acc_e) q_b.push_back(d);
            if (set_o) m_b_ovf = 1'b1;
            if (set_u) m_b_unf = 1'b1;
        end
        #1 check_b();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset overrides simultaneous requests
        step_a(1'b1, 1'b1, 8'hAA, 1'b1);
        step_a(1'b1, 1'b0, 8'h00, 1'b0);

        // Ten enqueues into an 8-deep FIFO: last two dropped
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("a_full_after_fill", 32'(a_full), 32'd1);

        // Ten dequeues: eight words in order, then ignored requests
        for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 8'h00, 1'b1);
        chk("a_empty_after_drain", 32'(a_empty), 32'd1);

        // Reset while partially full, then refill and drain
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 8'($urandom), 1'b0);
        step_a(1'b1, 1'b0, 8'h00, 1'b0);
        chk("a_out_zero_after_reset", 32'(a_out_data), 32'd0);
        for (int i = 0; i < 8; i++) step_a(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) step_a(1'b0, 1'b0, 8'h00, 1'b1);

        // Steady-state simultaneous traffic at four words, wrapping pointers
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step_a(1'b0, 1'b1, 8'($urandom), 1'b1);

        // Simultaneous request when full: dequeue only
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, 8'($urandom), 1'b0);
        step_a(1'b0, 1'b1, 8'h5A, 1'b1);
        chk("a_full_drop_after_both", 32'(a_full), 32'd0);

        // Simultaneous request when empty: enqueue only, no bypass
        for (int i = 0; i < 7; i++) step_a(1'b0, 1'b0, 8'h00, 1'b1);
        step_a(1'b0, 1'b1, 8'hC3, 1'b1);
        chk("a_head_after_empty_both", 32'(a_out_data), 32'hC3);
        step_a(1'b0, 1'b0, 8'h00, 1'b1);

        // Non-power-of-two depth: fill and drain twice
        step_b(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) step_b(1'b0, 1'b1, 16'($urandom), 1'b0);
            chk("b_full_at_5", 32'(b_full), 32'd1);
            step_b(1'b0, 1'b1, 16'hDEAD, 1'b0);
            for (int i = 0; i < 5; i++) step_b(1'b0, 1'b0, 16'h0000, 1'b1);
            step_b(1'b0, 1'b0, 16'h0000, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
